uart_cmd_trigger: RTL and testbench

Command front-end that sits directly upstream of the pulse generator. It consumes bytes from the UART receiver, parses fixed 5-byte command frames, and drives the generator's `uart_flag` trigger input. It also holds the run-time pulse-width and channel-enable registers. Malformed, timed-out or rejected frames are dropped and counted, so a noisy serial link cannot produce a spurious pulse.

---
 rtl/uart_cmd_trigger_pkg.sv | 25 ++
 rtl/uart_cmd_trigger_trig_stretch.sv | 37 +++
 rtl/uart_cmd_trigger.sv | 153 +++++++++++++++
 tb/tb_uart_cmd_trigger.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_trigger_pkg.sv
// Shared definitions for the UART command front-end: command codes,
// default frame header and the frame parser state encoding.
package uart_cmd_pkg;

   localparam logic [7:0] CMD_FIRE      = 8'h01;
   localparam logic [7:0] CMD_SET_WIDTH = 8'h02;
   localparam logic [7:0] CMD_SET_CH    = 8'h03;

   localparam logic [7:0] DEF_HDR_BYTE  = 8'h55;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DHI,
      ST_DLO,
      ST_CHK
   } state_t;

   function automatic logic [7:0] calcChk(input logic [7:0] cmd,
                                          input logic [7:0] dHi,
                                          input logic [7:0] dLo);
      return cmd ^ dHi ^ dLo;
   endfunction

endpackage

// File: rtl/uart_cmd_trigger_trig_stretch.sv
// Stretches a single-cycle fire strobe into a TRIG_HOLD-cycle level so it
// survives the crossing into the slower PLL clock domain.
module trig_stretch #(
   parameter int TRIG_HOLD = 4
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic fire,
   output logic uart_flag,
   output logic hold_busy
);

   localparam logic [7:0] HOLD_VAL = 8'(TRIG_HOLD);

   logic [7:0] r_holdCnt;
   logic       r_flag;

   // The flag is kept as its own register so the level seen by the other
   // clock domain never glitches; a fire while holding reloads the counter,
   // so callers that must not extend the pulse have to gate fire themselves.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_holdCnt <= 8'd0;
         r_flag    <= 1'b0;
      end else if (fire) begin
         r_holdCnt <= HOLD_VAL;
         r_flag    <= 1'b1;
      end else if (r_holdCnt != 8'd0) begin
         r_holdCnt <= r_holdCnt - 8'd1;
         r_flag    <= (r_holdCnt != 8'd1);
      end
   end

   assign uart_flag = r_flag;
   assign hold_busy = (r_holdCnt != 8'd0);

endmodule

// File: rtl/uart_cmd_trigger.sv
// Parses 5-byte UART command frames (HDR CMD D_HI D_LO CHK), drives the pulse
// generator trigger and holds the pulse-width / channel-enable registers.
module uart_cmd_trigger
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0]  HDR_BYTE    = DEF_HDR_BYTE,
   parameter int          TRIG_HOLD   = 4,
   parameter int          TIMEOUT_CYC = 500_000,
   parameter logic [15:0] DEF_WIDTH   = 16'd1000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        uart_flag,
   output logic [15:0] pulse_width,
   output logic [1:0]  ch_en,
   output logic        busy,
   output logic        cmd_err,
   output logic [7:0]  err_cnt
);

   localparam logic [19:0] TIMEOUT_VAL = 20'(TIMEOUT_CYC);

   state_t      r_state;
   state_t      w_nextState;
   logic [7:0]  r_cmd;
   logic [7:0]  r_dHi;
   logic [7:0]  r_dLo;
   logic [19:0] r_gap;
   logic [15:0] r_pulseWidth;
   logic [1:0]  r_chEn;
   logic        r_err;
   logic [7:0]  r_errCnt;

   logic        w_timeout;
   logic        w_fire;
   logic        w_err;
   logic        w_setWidth;
   logic        w_setCh;
   logic        w_flag;
   logic        w_holdBusy;

   // A received byte always takes priority over an expiring gap counter.
   assign w_timeout = (r_state != ST_IDLE) && !rx_valid && (r_gap == TIMEOUT_VAL);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // All command side effects are decided on the CHK byte; a FIRE while the
   // trigger is still held is refused because the downstream edge detector
   // would never see a second rising edge.
   always_comb begin
      w_nextState = r_state;
      w_fire      = 1'b0;
      w_err       = 1'b0;
      w_setWidth  = 1'b0;
      w_setCh     = 1'b0;
      if (rx_valid) begin
         unique case (r_state)
            ST_IDLE: if (rx_data == HDR_BYTE) w_nextState = ST_CMD;
            ST_CMD:  w_nextState = ST_DHI;
            ST_DHI:  w_nextState = ST_DLO;
            ST_DLO:  w_nextState = ST_CHK;
            ST_CHK: begin
               w_nextState = ST_IDLE;
               if (rx_data != calcChk(r_cmd, r_dHi, r_dLo)) begin
                  w_err = 1'b1;
               end else begin
                  case (r_cmd)
                     CMD_FIRE: begin
                        if (w_flag) w_err = 1'b1;
                        else        w_fire = 1'b1;
                     end
                     CMD_SET_WIDTH: begin
                        if ({r_dHi, r_dLo} == 16'd0) w_err = 1'b1;
                        else                          w_setWidth = 1'b1;
                     end
                     CMD_SET_CH: w_setCh = 1'b1;
                     default:    w_err = 1'b1;
                  endcase
               end
            end
            default: w_nextState = ST_IDLE;
         endcase
      end else if (w_timeout) begin
         w_nextState = ST_IDLE;
         w_err       = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_cmd <= 8'd0;
         r_dHi <= 8'd0;
         r_dLo <= 8'd0;
      end else if (rx_valid) begin
         case (r_state)
            ST_CMD: r_cmd <= rx_data;
            ST_DHI: r_dHi <= rx_data;
            ST_DLO: r_dLo <= rx_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_gap <= 20'd0;
      end else if (rx_valid || (r_state == ST_IDLE) || w_timeout) begin
         r_gap <= 20'd0;
      end else begin
         r_gap <= r_gap + 20'd1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_pulseWidth <= DEF_WIDTH;
         r_chEn       <= 2'b11;
         r_err        <= 1'b0;
         r_errCnt     <= 8'd0;
      end else begin
         if (w_setWidth) r_pulseWidth <= {r_dHi, r_dLo};
         if (w_setCh)    r_chEn       <= r_dLo[1:0];
         r_err <= w_err;
         if (w_err && (r_errCnt != 8'hFF)) r_errCnt <= r_errCnt + 8'd1;
      end
   end

   trig_stretch #(
      .TRIG_HOLD (TRIG_HOLD)
   ) u_trig_stretch (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .fire      (w_fire),
      .uart_flag (w_flag),
      .hold_busy (w_holdBusy)
   );

   assign uart_flag   = w_flag;
   assign pulse_width = r_pulseWidth;
   assign ch_en       = r_chEn;
   assign busy        = (r_state != ST_IDLE) || w_holdBusy;
   assign cmd_err     = r_err;
   assign err_cnt     = r_errCnt;

endmodule

// File: tb/tb_uart_cmd_trigger.sv
// Self-checking bench for uart_cmd_trigger: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_uart_cmd_trigger;

   localparam int          HOLD    = 7;
   localparam int          TMO     = 40;
   localparam logic [15:0] DEFW    = 16'd1234;
   localparam logic [7:0]  HDR     = 8'h55;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        uart_flag;
   logic [15:0] pulse_width;
   logic [1:0]  ch_en;
   logic        busy;
   logic        cmd_err;
   logic [7:0]  err_cnt;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;

   // Reference model state: registers as the command rules define them, plus
   // the edge index of the last accepted FIRE.
   logic [15:0] mPw;
   logic [1:0]  mCh;
   int          mErrCnt;
   int          mLastFire;

   uart_cmd_trigger #(
      .HDR_BYTE    (HDR),
      .TRIG_HOLD   (HOLD),
      .TIMEOUT_CYC (TMO),
      .DEF_WIDTH   (DEFW)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .uart_flag   (uart_flag),
      .pulse_width (pulse_width),
      .ch_en       (ch_en),
      .busy        (busy),
      .cmd_err     (cmd_err),
      .err_cnt     (err_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic logic expFlag(input int c);
      return ((c - mLastFire) >= 0) && ((c - mLastFire) < HOLD);
   endfunction

   task automatic modelReset();
      mPw = DEFW;
      mCh = 2'b11;
      mErrCnt = 0;
      mLastFire = -1000;
   endtask

   task automatic modelFrame(input logic [7:0] cmd, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] chk, input int c, output logic expErr);
      expErr = 1'b0;
      if (chk != (cmd ^ hi ^ lo)) expErr = 1'b1;
      else if (cmd == 8'h01) begin
         if ((c - mLastFire) <= HOLD) expErr = 1'b1;
         else mLastFire = c;
      end else if (cmd == 8'h02) begin
         if ({hi, lo} == 16'd0) expErr = 1'b1;
         else mPw = {hi, lo};
      end else if (cmd == 8'h03) mCh = lo[1:0];
      else expErr = 1'b1;
      if (expErr && mErrCnt < 255) mErrCnt++;
   endtask

   // Called at a negedge; returns at the negedge following the sampling edge.
   task automatic applyStimulus(input logic [7:0] b, output int edgeIdx);
      rx_data = b;
      rx_valid = 1'b1;
      edgeIdx = cyc + 1;
      @(negedge sys_clk);
      rx_valid = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] chk, input int maxGap, output int chkEdge);
      logic [7:0] bytes [5];
      bytes = '{HDR, cmd, hi, lo, chk};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(bytes[i], chkEdge);
         if (i < 4 && maxGap > 0) repeat ($urandom_range(0, maxGap)) @(negedge sys_clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sys_clk);
      testsRun++; if (uart_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flag got %0b want 0", uart_flag); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
      testsRun++; if (cmd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err got %0b want 0", cmd_err); end
      testsRun++; if (err_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_errcnt got %0d want 0", err_cnt); end
      testsRun++; if (pulse_width !== DEFW) begin testsFailed++; $display("[TB] FAIL reset_width got %0d want %0d", pulse_width, DEFW); end
      testsRun++; if (ch_en !== 2'b11) begin testsFailed++; $display("[TB] FAIL reset_ch got %b want 11", ch_en); end
      sys_rst = 1'b0;
      modelReset();
      @(negedge sys_clk);
   endtask

   task automatic test_fire();
      int e;
      logic ee;
      sendFrame(8'h01, 8'h00, 8'h00, 8'h01, 0, e);
      modelFrame(8'h01, 8'h00, 8'h00, 8'h01, e, ee);
      for (int k = 0; k <= HOLD + 1; k++) begin
         testsRun++; if (uart_flag !== (k < HOLD)) begin testsFailed++; $display("[TB] FAIL fire_flag k=%0d got %0b want %0b", k, uart_flag, (k < HOLD)); end
         testsRun++; if (cmd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL fire_err k=%0d got %0b want 0", k, cmd_err); end
         @(negedge sys_clk);
      end
   endtask

   task automatic test_set_width();
      int e;
      logic ee;
      sendFrame(8'h02, 8'h01, 8'hF4, 8'hF7, 0, e);
      modelFrame(8'h02, 8'h01, 8'hF4, 8'hF7, e, ee);
      testsRun++; if (pulse_width !== 16'd500) begin testsFailed++; $display("[TB] FAIL width_set got %0d want 500", pulse_width); end
      testsRun++; if (cmd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL width_err got %0b want 0", cmd_err); end
      sendFrame(8'h02, 8'h00, 8'h00, 8'h02, 0, e);
      modelFrame(8'h02, 8'h00, 8'h00, 8'h02, e, ee);
      testsRun++; if (cmd_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL width_zero_err got %0b want 1", cmd_err); end
      testsRun++; if (pulse_width !== 16'd500) begin testsFailed++; $display("[TB] FAIL width_kept got %0d want 500", pulse_width); end
      testsRun++; if (err_cnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL width_errcnt got %0d want 1", err_cnt); end
      @(negedge sys_clk);
      testsRun++; if (cmd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_one_cycle got %0b want 0", cmd_err); end
   endtask

   task automatic test_set_ch();
      int e;
      logic ee;
      sendFrame(8'h03, 8'h00, 8'h02, 8'h01, 0, e);
      modelFrame(8'h03, 8'h00, 8'h02, 8'h01, e, ee);
      testsRun++; if (ch_en !== 2'b10) begin testsFailed++; $display("[TB] FAIL ch_set got %b want 10", ch_en); end
      sendFrame(8'h03, 8'h00, 8'h01, 8'h00, 0, e);
      modelFrame(8'h03, 8'h00, 8'h01, 8'h00, e, ee);
      testsRun++; if (cmd_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL ch_badchk_err got %0b want 1", cmd_err); end
      testsRun++; if (ch_en !== 2'b10) begin testsFailed++; $display("[TB] FAIL ch_kept got %b want 10", ch_en); end
      testsRun++; if (err_cnt !== 8'(mErrCnt)) begin testsFailed++; $display("[TB] FAIL ch_errcnt got %0d want %0d", err_cnt, mErrCnt); end
   endtask

   task automatic test_timeout();
      int e;
      logic ee;
      applyStimulus(HDR, e);
      applyStimulus(8'h01, e);
      // The gap reaches TMO TMO cycles after the last byte; the error shows one cycle later.
      for (int k = 1; k <= TMO + 3; k++) begin
         @(negedge sys_clk);
         testsRun++; if (cmd_err !== (k == TMO + 1)) begin testsFailed++; $display("[TB] FAIL timeout_err k=%0d got %0b want %0b", k, cmd_err, (k == TMO + 1)); end
         if (k == TMO) begin
            testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_busy_before got %0b want 1", busy); end
         end
         if (k == TMO + 1) begin
            testsRun++; if (busy !== expFlag(cyc)) begin testsFailed++; $display("[TB] FAIL timeout_busy_after got %0b want %0b", busy, expFlag(cyc)); end
         end
      end
      if (mErrCnt < 255) mErrCnt++;
      testsRun++; if (err_cnt !== 8'(mErrCnt)) begin testsFailed++; $display("[TB] FAIL timeout_errcnt got %0d want %0d", err_cnt, mErrCnt); end
      sendFrame(8'h01, 8'h00, 8'h00, 8'h01, 0, e);
      modelFrame(8'h01, 8'h00, 8'h00, 8'h01, e, ee);
      testsRun++; if (uart_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_refire got %0b want 1", uart_flag); end
      testsRun++; if (cmd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_refire_err got %0b want 0", cmd_err); end
      repeat (HOLD + 2) @(negedge sys_clk);
      // A byte landing on the very edge the timeout would fire must win.
      applyStimulus(HDR, e);
      applyStimulus(8'h01, e);
      repeat (TMO) @(negedge sys_clk);
      applyStimulus(8'h00, e);
      testsRun++; if (cmd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_edge_err got %0b want 0", cmd_err); end
      applyStimulus(8'h00, e);
      applyStimulus(8'h01, e);
      modelFrame(8'h01, 8'h00, 8'h00, 8'h01, e, ee);
      testsRun++; if (uart_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_edge_fire got %0b want 1", uart_flag); end
      testsRun++; if (err_cnt !== 8'(mErrCnt)) begin testsFailed++; $display("[TB] FAIL timeout_edge_errcnt got %0d want %0d", err_cnt, mErrCnt); end
      repeat (HOLD + 2) @(negedge sys_clk);
   endtask

   task automatic test_back_to_back();
      int e1;
      int e2;
      logic ee;
      sendFrame(8'h01, 8'h00, 8'h00, 8'h01, 0, e1);
      modelFrame(8'h01, 8'h00, 8'h00, 8'h01, e1, ee);
      sendFrame(8'h01, 8'h00, 8'h00, 8'h01, 0, e2);
      modelFrame(8'h01, 8'h00, 8'h00, 8'h01, e2, ee);
      testsRun++; if (cmd_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_err got %0b want 1", cmd_err); end
      testsRun++; if (err_cnt !== 8'(mErrCnt)) begin testsFailed++; $display("[TB] FAIL b2b_errcnt got %0d want %0d", err_cnt, mErrCnt); end
      while (cyc <= e1 + HOLD + 1) begin
         testsRun++; if (uart_flag !== (cyc < e1 + HOLD)) begin testsFailed++; $display("[TB] FAIL b2b_flag cyc=%0d got %0b want %0b", cyc - e1, uart_flag, (cyc < e1 + HOLD)); end
         @(negedge sys_clk);
      end
   endtask

   task automatic test_random();
      int e;
      logic ee;
      logic [7:0] cmd, hi, lo, chk, nb;
      for (int f = 0; f < 60; f++) begin
         repeat ($urandom_range(0, 2)) begin
            nb = 8'($urandom_range(0, 255));
            if (nb == HDR) nb = 8'h54;
            applyStimulus(nb, e);
         end
         testsRun++; if (cmd_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd_noise f=%0d got %0b want 0", f, cmd_err); end
         case ($urandom_range(0, 3))
            0: cmd = 8'h01;
            1: cmd = 8'h02;
            2: cmd = 8'h03;
            default: cmd = 8'($urandom_range(4, 255));
         endcase
         hi = 8'($urandom_range(0, 255));
         lo = 8'($urandom_range(0, 255));
         if (cmd == 8'h02 && $urandom_range(0, 3) == 0) begin hi = 8'h00; lo = 8'h00; end
         chk = cmd ^ hi ^ lo;
         if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
         sendFrame(cmd, hi, lo, chk, 3, e);
         modelFrame(cmd, hi, lo, chk, e, ee);
         testsRun++; if (cmd_err !== ee) begin testsFailed++; $display("[TB] FAIL rnd_err f=%0d got %0b want %0b", f, cmd_err, ee); end
         testsRun++; if (pulse_width !== mPw) begin testsFailed++; $display("[TB] FAIL rnd_width f=%0d got %0d want %0d", f, pulse_width, mPw); end
         testsRun++; if (ch_en !== mCh) begin testsFailed++; $display("[TB] FAIL rnd_ch f=%0d got %b want %b", f, ch_en, mCh); end
         testsRun++; if (err_cnt !== 8'(mErrCnt)) begin testsFailed++; $display("[TB] FAIL rnd_errcnt f=%0d got %0d want %0d", f, err_cnt, mErrCnt); end
         testsRun++; if (uart_flag !== expFlag(cyc)) begin testsFailed++; $display("[TB] FAIL rnd_flag f=%0d got %0b want %0b", f, uart_flag, expFlag(cyc)); end
         testsRun++; if (busy !== expFlag(cyc)) begin testsFailed++; $display("[TB] FAIL rnd_busy f=%0d got %0b want %0b", f, busy, expFlag(cyc)); end
         repeat ($urandom_range(0, 8)) @(negedge sys_clk);
      end
   endtask

   task automatic test_saturation();
      int e;
      logic ee;
      for (int f = 0; f < 300; f++) begin
         sendFrame(8'h03, 8'h00, 8'h01, 8'h00, 0, e);
         modelFrame(8'h03, 8'h00, 8'h01, 8'h00, e, ee);
         if (f == 100) begin
            testsRun++; if (err_cnt !== 8'(mErrCnt)) begin testsFailed++; $display("[TB] FAIL sat_mid got %0d want %0d", err_cnt, mErrCnt); end
         end
      end
      testsRun++; if (err_cnt !== 8'd255) begin testsFailed++; $display("[TB] FAIL sat_cnt got %0d want 255", err_cnt); end
      testsRun++; if (cmd_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_err got %0b want 1", cmd_err); end
   endtask

   task automatic test_reset_midframe();
      int e;
      logic ee;
      repeat (HOLD + 2) @(negedge sys_clk);
      sendFrame(8'h01, 8'h00, 8'h00, 8'h01, 0, e);
      modelFrame(8'h01, 8'h00, 8'h00, 8'h01, e, ee);
      applyStimulus(HDR, e);
      applyStimulus(8'h02, e);
      testsRun++; if (uart_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL pre_rst_flag got %0b want 1", uart_flag); end
      testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL pre_rst_busy got %0b want 1", busy); end
      #1 sys_rst = 1'b1;
      #1;
      testsRun++; if (uart_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_flag got %0b want 0", uart_flag); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_busy got %0b want 0", busy); end
      testsRun++; if (err_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL rst_errcnt got %0d want 0", err_cnt); end
      testsRun++; if (pulse_width !== DEFW) begin testsFailed++; $display("[TB] FAIL rst_width got %0d want %0d", pulse_width, DEFW); end
      testsRun++; if (ch_en !== 2'b11) begin testsFailed++; $display("[TB] FAIL rst_ch got %b want 11", ch_en); end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      modelReset();
      @(negedge sys_clk);
      sendFrame(8'h03, 8'h00, 8'h01, 8'h02, 0, e);
      modelFrame(8'h03, 8'h00, 8'h01, 8'h02, e, ee);
      testsRun++; if (ch_en !== 2'b01) begin testsFailed++; $display("[TB] FAIL post_rst_ch got %b want 01", ch_en); end
      testsRun++; if (cmd_err !== 1'b0 || err_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL post_rst_err got %0b/%0d want 0/0", cmd_err, err_cnt); end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_fire();
      test_set_width();
      test_set_ch();
      test_timeout();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
